// File: rtl/dm_jtag_dtm.sv
// JTAG DTM: oversampled 1149.1 TAP exposing DTMCS, DMI and (with DTM_IDCODE_EN) IDCODE.
// Latency: a TCK edge acts 3 clk after the pin edge; a DMI update raises dmi_valid on the next clk.
// Backpressure: dmi_valid holds until dmi_ready; a scan meeting an unfinished request sets sticky busy.
module dm_jtag_dtm #(
    parameter int          ABITS  = 7,
    parameter logic [31:0] IDCODE = 32'h1000_0A6F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             jtag_tck,
    input  logic             jtag_tms,
    input  logic             jtag_tdi,
    output logic             jtag_tdo,
    output logic             jtag_tdo_en,
    output logic             dmi_valid,
    input  logic             dmi_ready,
    output logic             dmi_write,
    output logic [ABITS-1:0] dmi_addr,
    output logic [31:0]      dmi_wdata,
    input  logic [31:0]      dmi_rdata
);

    localparam int          DRW     = ABITS + 34;
    localparam logic [5:0]  ABITS_F = 6'(ABITS);
`ifdef DTM_IDCODE_EN
    localparam logic [4:0]  IR_TLR  = 5'h01;
`else
    localparam logic [4:0]  IR_TLR  = 5'h1F;
`endif

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_t;
    typedef enum logic [1:0] {D_IDLE, D_REQ, D_RESP} dmi_state_t;

    logic [1:0]     tck_s, tms_s, tdi_s;
    logic           tck_q, tck_rise, tck_fall, tms, tdi;
    tap_state_t     tap_state, tap_next;
    dmi_state_t     dmi_st, dmi_nx;
    dr_sel_t        dr_sel;
    logic [4:0]     ir, ir_sr;
    logic [DRW-1:0] dr_sr, dmi_cap;
    logic [31:0]    dtmcs_cap, last_rdata;
    logic           busy, issue;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tck_s <= '0;
            tms_s <= '0;
            tdi_s <= '0;
            tck_q <= 1'b0;
        end else begin
            tck_s <= {tck_s[0], jtag_tck};
            tms_s <= {tms_s[0], jtag_tms};
            tdi_s <= {tdi_s[0], jtag_tdi};
            tck_q <= tck_s[1];
        end
    end

    assign tck_rise = tck_s[1] & ~tck_q;
    assign tck_fall = ~tck_s[1] & tck_q;
    assign tms      = tms_s[1];
    assign tdi      = tdi_s[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tap_state <= TLR;
        else       tap_state <= tap_next;
    end

    always_comb begin
        tap_next = tap_state;
        if (tck_rise) begin
            case (tap_state)
                TLR:      tap_next = tms ? TLR      : RTI;
                RTI:      tap_next = tms ? SEL_DR   : RTI;
                SEL_DR:   tap_next = tms ? SEL_IR   : CAP_DR;
                CAP_DR:   tap_next = tms ? EX1_DR   : SHIFT_DR;
                SHIFT_DR: tap_next = tms ? EX1_DR   : SHIFT_DR;
                EX1_DR:   tap_next = tms ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: tap_next = tms ? EX2_DR   : PAUSE_DR;
                EX2_DR:   tap_next = tms ? UPD_DR   : SHIFT_DR;
                UPD_DR:   tap_next = tms ? SEL_DR   : RTI;
                SEL_IR:   tap_next = tms ? TLR      : CAP_IR;
                CAP_IR:   tap_next = tms ? EX1_IR   : SHIFT_IR;
                SHIFT_IR: tap_next = tms ? EX1_IR   : SHIFT_IR;
                EX1_IR:   tap_next = tms ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: tap_next = tms ? EX2_IR   : PAUSE_IR;
                EX2_IR:   tap_next = tms ? UPD_IR   : SHIFT_IR;
                UPD_IR:   tap_next = tms ? SEL_DR   : RTI;
                default:  tap_next = TLR;
            endcase
        end
    end

    always_comb begin
        dr_sel = DR_BYPASS;
        case (ir)
`ifdef DTM_IDCODE_EN
            5'h01:   dr_sel = DR_IDCODE;
`endif
            5'h10:   dr_sel = DR_DTMCS;
            5'h11:   dr_sel = DR_DMI;
            default: dr_sel = DR_BYPASS;
        endcase
    end

    assign dtmcs_cap = {14'h0, 1'b0, 1'b0, 1'b0, 3'd1, busy ? 2'd3 : 2'd0, ABITS_F, 4'd1};
    assign dmi_cap   = {dmi_addr, last_rdata, (busy || dmi_st != D_IDLE) ? 2'd3 : 2'd0};

    // Only an idle, non-busy DMI update with a read or write op starts a bus request.
    assign issue = tck_fall && tap_state == UPD_DR && dr_sel == DR_DMI && !busy &&
                   dmi_st == D_IDLE && (dr_sr[1:0] == 2'd1 || dr_sr[1:0] == 2'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir          <= 5'h01;
            ir_sr       <= 5'h01;
            dr_sr       <= '0;
            busy        <= 1'b0;
            jtag_tdo    <= 1'b0;
            jtag_tdo_en <= 1'b0;
        end else begin
            if (tck_rise) begin
                if (tap_next == TLR) ir <= IR_TLR;
                case (tap_state)
                    CAP_IR:   ir_sr <= 5'b00001;
                    SHIFT_IR: ir_sr <= {tdi, ir_sr[4:1]};
                    CAP_DR: begin
                        case (dr_sel)
                            DR_IDCODE: dr_sr <= {{(DRW-32){1'b0}}, IDCODE};
                            DR_DTMCS:  dr_sr <= {{(DRW-32){1'b0}}, dtmcs_cap};
                            DR_DMI: begin
                                dr_sr <= dmi_cap;
                                if (dmi_st != D_IDLE) busy <= 1'b1;
                            end
                            default:   dr_sr <= '0;
                        endcase
                    end
                    SHIFT_DR: begin
                        case (dr_sel)
                            DR_DMI:    dr_sr <= {tdi, dr_sr[DRW-1:1]};
                            DR_BYPASS: dr_sr <= {{(DRW-1){1'b0}}, tdi};
                            default:   dr_sr <= {{(DRW-32){1'b0}}, tdi, dr_sr[31:1]};
                        endcase
                    end
                    default: ;
                endcase
            end
            if (tck_fall) begin
                jtag_tdo    <= (tap_state == SHIFT_IR) ? ir_sr[0] : dr_sr[0];
                jtag_tdo_en <= (tap_state == SHIFT_IR) || (tap_state == SHIFT_DR);
                if (tap_state == UPD_IR) ir <= ir_sr;
                if (tap_state == UPD_DR && dr_sel == DR_DTMCS && (dr_sr[16] || dr_sr[17]))
                    busy <= 1'b0;
                if (tap_state == UPD_DR && dr_sel == DR_DMI && !busy && dmi_st != D_IDLE)
                    busy <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmi_st     <= D_IDLE;
            dmi_write  <= 1'b0;
            dmi_addr   <= '0;
            dmi_wdata  <= '0;
            last_rdata <= '0;
        end else begin
            dmi_st <= dmi_nx;
            if (issue) begin
                dmi_addr  <= dr_sr[DRW-1:34];
                dmi_wdata <= dr_sr[33:2];
                dmi_write <= (dr_sr[1:0] == 2'd2);
            end
            // Read data arrives the cycle after the handshake.
            if (dmi_st == D_RESP && !dmi_write) last_rdata <= dmi_rdata;
        end
    end

    always_comb begin
        dmi_nx = dmi_st;
        case (dmi_st)
            D_IDLE:  if (issue) dmi_nx = D_REQ;
            D_REQ:   if (dmi_ready) dmi_nx = D_RESP;
            D_RESP:  dmi_nx = D_IDLE;
            default: dmi_nx = D_IDLE;
        endcase
    end

    assign dmi_valid = (dmi_st == D_REQ);

endmodule

// File: doc/dm_jtag_dtm.md
Name: dm_jtag_dtm

Overview:
JTAG Debug Transport Module, placed directly upstream of the debug module. It decodes a JTAG TAP (IEEE 1149.1) and exposes the RISC-V DTM registers IDCODE, DTMCS and DMI. Each DMI scan becomes a single valid/ready transaction on the DMI bus that the debug module consumes. JTAG pins are oversampled in the single clk domain, so there is no separate TCK clock domain.

Parameters:
ABITS, 7, DMI address width; drives the dmi_addr width and the DTMCS.abits field.
IDCODE, 32'h1000_0A6F, JTAG IDCODE value; bit 0 must be 1.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
jtag_tck  input  1  JTAG clock pin; treated as asynchronous data.
jtag_tms  input  1  JTAG mode select; asynchronous.
jtag_tdi  input  1  JTAG data in; asynchronous.
jtag_tdo  output  1  JTAG data out (registered).
jtag_tdo_en  output  1  TDO drive enable.
dmi_valid  output  1  DMI request valid.
dmi_ready  input  1  DMI ready from the debug module.
dmi_write  output  1  1 = write, 0 = read.
dmi_addr  output  ABITS  DMI register address.
dmi_wdata  output  32  DMI write data.
dmi_rdata  input  32  DMI read data.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: jtag_tdo=0, jtag_tdo_en=0, dmi_valid=0, dmi_write=0, dmi_addr=0, dmi_wdata=0.
  - TAP in Test-Logic-Reset; IR=5'h01; sticky busy=0; last-read data=0; DMI FSM in IDLE.
  - Reset mid-transaction drops dmi_valid immediately.
- Pin synchronisation:
  - tck, tms and tdi each pass through a 2-FF synchroniser.
  - A third tck register provides rise/fall detection.
  - TCK high and low phases must each last ≥3 clk periods.
  - An edge becomes effective 3 clk cycles after the pin edge.
- TCK rising edge: sample tms/tdi, advance the TAP FSM, perform capture/shift actions.
- TCK falling edge: jtag_tdo <= LSB of the active shift register; jtag_tdo_en=1 only in Shift-IR/Shift-DR.
- TAP FSM: full 16-state 1149.1 machine. Five consecutive TMS=1 rising edges reach Test-Logic-Reset from any state. Test-Logic-Reset loads IR=5'h01.
- IR (5 bits):
  - Capture-IR loads 5'b00001.
  - Shift-IR shifts LSB out first, TDI into the MSB.
  - Update-IR latches the new IR.
- DR select by IR:
  - 0x01: IDCODE, 32 bits.
  - 0x10: DTMCS, 32 bits.
  - 0x11: DMI, ABITS+34 bits.
  - All others: BYPASS, 1 bit, captured 0.
- DTMCS:
  - Capture value: {14'h0, dmihardreset=0, dmireset=0, 1'b0, idle=3'd1, dmistat[1:0], abits[5:0], version=4'd1}.
  - dmistat = 3 when sticky busy, else 0.
  - Update with bit16 or bit17 set clears sticky busy.
  - Any outstanding request still completes normally.
- DMI register layout: {addr[ABITS-1:0], data[31:0], op[1:0]}.
- DMI capture:
  - addr = last issued address; data = last read data.
  - op = 3 if sticky busy, else 0.
  - If the DMI FSM is not IDLE at capture, set sticky busy and capture op=3.
- DMI update:
  - Ignored if sticky busy is set.
  - If the FSM is not IDLE, the update is ignored and sticky busy is set.
  - Otherwise op=1 issues a read and op=2 issues a write; op=0 or 3 does nothing.
- DMI FSM:
  - IDLE -> REQ on issue: dmi_valid=1; addr, wdata and write held stable.
  - REQ: hold until dmi_valid && dmi_ready. dmi_valid falls in the cycle after the handshake; it is never withdrawn before the handshake.
  - REQ -> RESP on handshake.
  - RESP: one cycle. For reads, capture dmi_rdata into last-read data (dmi_rdata is valid the cycle after the handshake). Then return to IDLE.
- Writes leave last-read data unchanged.

Optional Feature:
DTM_IDCODE_EN.
- Defined: IR 0x01 selects the IDCODE register; Test-Logic-Reset and Capture-IR behave as above.
- Undefined: no IDCODE register. IR 0x01 selects BYPASS, and Test-Logic-Reset loads IR=5'h1F.

Test Plan:
- IDCODE read (macro defined): reset, TMS=1 ×5, navigate to Shift-DR, shift 32 bits -> TDO yields 32'h1000_0A6F LSB first; jtag_tdo_en=1 only while shifting.
- DTMCS read: IR=0x10, scan 32 bits -> 32'h0000_1071.
- DMI write: IR=0x11, scan {addr 7'h10, data 32'h8000_0001, op 2}, stub asserts ready 1 cycle after valid -> exactly one handshake with addr=0x10, write=1, wdata=32'h8000_0001; valid low the next cycle.
- DMI read: scan op 1 at addr 0x11 with stub rdata=32'h0000_0C82, then scan op 0 -> captured data=32'h0000_0C82, op=0.
- Busy: hold dmi_ready=0, issue a write, rescan DMI -> captured op=3 and DTMCS.dmistat=3. Further updates are ignored. Release ready, write DTMCS bit16=1 -> dmistat=0.
- Reset mid-REQ: assert reset while dmi_valid=1 -> dmi_valid=0 without a clk edge; after release, TAP is in Test-Logic-Reset and IR=0x01.
